// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the single system bus.
// One grant at a time. The grant is held until the bus controller reports
// completion, the owner drops its request, or the watchdog expires. Each
// release is followed by a one-cycle turnaround gap (RELEASE) and then an
// IDLE cycle in which the next arbitration takes place.
// All outputs are registered, so there is no combinational path from any
// input to any output.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic                           bus_done,
  output logic [NUM_MASTERS-1:0]         gnt,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_id,
  output logic                           bus_busy,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT);

  // Counter value seen in the TIMEOUT-th cycle of ownership.
  localparam logic [CW-1:0]          CNT_LAST = CW'(TIMEOUT - 1);
  // Reset value of last_id, chosen so that master 0 wins the first arbitration.
  localparam logic [IW-1:0]          ID_LAST  = IW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_id_q, last_id_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          gnt_id_q, gnt_id_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;

  logic                   any_req_s;
  logic [IW-1:0]          win_id_s;
  logic                   own_req_s;
  logic                   expire_s;
  logic                   release_s;
  logic                   timeout_s;

  // Round-robin pick: the first set request searching upward, with wrap,
  // from last+1. The loop runs from the lowest-priority candidate (last
  // itself) up to the highest (last+1), so the last hit is the winner.
  // Only meaningful when at least one request bit is set.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                            input logic [IW-1:0]          last);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    pick = last;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % NUM_MASTERS);
      pick = r[cand] ? cand : pick;
    end
    return pick;
  endfunction

  // Arbitration and ownership-termination events.
  // The terminating events are only acted on in OWN. A request drop in
  // the same cycle as expiry is an abandon, and bus_done always wins over
  // expiry, so the watchdog fires only while the owner is still requesting
  // and the transaction has not completed.
  assign any_req_s = |req;
  assign win_id_s  = rr_pick(req, last_id_q);
  assign own_req_s = req[gnt_id_q];
  assign expire_s  = (cnt_q == CNT_LAST);
  assign release_s = bus_done | ~own_req_s | expire_s;
  assign timeout_s = expire_s & ~bus_done & own_req_s;

  // State register; the synchronous reset also aborts ownership without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> OWN on any request, OWN -> RELEASE on a
  // terminating event, RELEASE -> IDLE unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_OWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (release_s) begin
          state_d = ST_REL;
        end else begin
          state_d = ST_OWN;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values: grant on arbitration, hold while
  // owning, and drop (with an optional watchdog pulse) on release.
  always_comb begin
    gnt_d     = {NUM_MASTERS{1'b0}};
    gnt_id_d  = {IW{1'b0}};
    to_d      = 1'b0;
    last_id_d = last_id_q;
    cnt_d     = {CW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt_d     = ONE_HOT0 << win_id_s;
          gnt_id_d  = win_id_s;
          last_id_d = win_id_s;
        end else begin
          gnt_d     = {NUM_MASTERS{1'b0}};
          gnt_id_d  = {IW{1'b0}};
        end
      end
      ST_OWN: begin
        if (release_s) begin
          to_d     = timeout_s;
        end else begin
          gnt_d    = gnt_q;
          gnt_id_d = gnt_id_q;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      ST_REL: begin
        to_d = 1'b0;
      end
      default: begin
        to_d = 1'b0;
      end
    endcase
    busy_d = |gnt_d;
  end

  // Output and datapath registers with their reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q <= ID_LAST;
      cnt_q     <= {CW{1'b0}};
      gnt_q     <= {NUM_MASTERS{1'b0}};
      gnt_id_q  <= {IW{1'b0}};
      busy_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      to_q      <= to_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign bus_busy    = busy_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (NUM_MASTERS = 4, TIMEOUT = 8).
// Each step drives one cycle of inputs and pushes the outputs expected in
// the following cycle; after the edge the entry is popped and compared.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       bus_done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  bus_arbiter #(
    .NUM_MASTERS(4),
    .TIMEOUT    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .bus_done   (bus_done),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Drive one cycle, queue the expected response, advance, then compare.
  task automatic drive(input logic r_rst, input logic [3:0] r_req, input logic r_done,
                       input logic [3:0] e_gnt, input logic e_to, input string tag);
    exp_t e;
    rst      = r_rst;
    req      = r_req;
    bus_done = r_done;
    e.gnt  = e_gnt;
    e.id   = idx_of(e_gnt);
    e.busy = |e_gnt;
    e.to   = e_to;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (gnt === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt: got %b expected %b", e.tag, gnt, e.gnt);
    end
    checks++;
    assert (gnt_id === e.id) else begin
      errors++;
      $error("FAIL %s gnt_id: got %0d expected %0d", e.tag, gnt_id, e.id);
    end
    checks++;
    assert (bus_busy === e.busy) else begin
      errors++;
      $error("FAIL %s bus_busy: got %b expected %b", e.tag, bus_busy, e.busy);
    end
    checks++;
    assert (timeout_err === e.to) else begin
      errors++;
      $error("FAIL %s timeout_err: got %b expected %b", e.tag, timeout_err, e.to);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b1111;
    bus_done = 1'b0;

    // Reset held two cycles with every master requesting.
    drive(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, "reset0");
    drive(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, "reset1");

    // Round-robin from reset: 0,1,2,3,0, bus_done 3 cycles after each grant.
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (g % 4);
      drive(1'b0, 4'b1111, 1'b0, oh, 1'b0, $sformatf("rr%0d_grant", g));
      for (int c = 0; c < 3; c++) begin
        drive(1'b0, 4'b1111, 1'b0, oh, 1'b0, $sformatf("rr%0d_hold%0d", g, c));
      end
      drive(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, $sformatf("rr%0d_rel", g));
      drive(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, $sformatf("rr%0d_gap", g));
    end
    // last winner was master 0; we are now in IDLE.
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "idle_noreq");

    // Single master 2: grant cycles 1-5, bus_done at cycle 5, zero at 6-7.
    drive(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, "single_c1");
    for (int c = 2; c <= 5; c++) begin
      drive(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, $sformatf("single_c%0d", c));
    end
    drive(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, "single_c6");
    // bus_done during RELEASE and IDLE must be ignored.
    drive(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "single_c7_done_rel");
    drive(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "done_in_idle");

    // Watchdog: master 1 held, no bus_done -> gnt cycles 1-8, timeout at 9.
    drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, "wd_c1");
    for (int c = 2; c <= 8; c++) begin
      drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, $sformatf("wd_c%0d", c));
    end
    drive(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, "wd_c9_timeout");
    drive(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, "wd_c10_pulse_end");

    // Repeat with bus_done in cycle 8: normal completion, no timeout_err.
    drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, "wd2_c1");
    for (int c = 2; c <= 8; c++) begin
      drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, $sformatf("wd2_c%0d", c));
    end
    drive(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, "wd2_c9_done_wins");
    drive(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, "wd2_c10");

    // Request dropped in the expiry cycle: abandon, no timeout_err.
    drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, "wd3_c1");
    for (int c = 2; c <= 8; c++) begin
      drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, $sformatf("wd3_c%0d", c));
    end
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "wd3_c9_drop_wins");
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "wd3_c10");

    // Abandon: master 3 wins (last was 1), drops in 3rd OWN cycle, req[0] held.
    drive(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b0, "ab_own1");
    drive(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b0, "ab_own2");
    drive(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b0, "ab_own3");
    drive(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, "ab_rel");
    drive(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, "ab_idle");
    drive(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, "ab_m0_grant");
    // Other masters' requests changing during OWN do not disturb the owner.
    drive(1'b0, 4'b0111, 1'b0, 4'b0001, 1'b0, "ab_other_req");
    drive(1'b0, 4'b0101, 1'b1, 4'b0000, 1'b0, "ab_m0_done");
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "ab_m0_gap");

    // Reset mid-ownership: master 1 granted (last was 0), then rst.
    drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, "mr_own1");
    drive(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, "mr_own2");
    drive(1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, "mr_reset");
    drive(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0, "mr_first_m0");
    drive(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "mr_done_and_drop");
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "mr_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
